// File: rtl/eth_pkg.sv
// Shared Ethernet constants: wire symbols, CRC-32 parameters and the TX framer state encoding.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t StIdle = 3'd0;
  localparam tx_state_t StPre  = 3'd1;
  localparam tx_state_t StSfd  = 3'd2;
  localparam tx_state_t StData = 3'd3;
  localparam tx_state_t StPad  = 3'd4;
  localparam tx_state_t StFcs  = 3'd5;
  localparam tx_state_t StIfg  = 3'd6;

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32 (no final inversion).
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_mac_tx.sv
// Ethernet transmit framer: preamble, SFD, payload, zero pad, FCS and inter-frame gap,
// one registered GMII-style byte per clk.
module eth_mac_tx
  import eth_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_PAYLOAD  = 60,
  parameter int unsigned IFG_LEN      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       s_error,
  output logic       tx_valid,
  output logic       tx_error,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CntW = 16;

  localparam logic [CntW-1:0] PreLast = CntW'(PREAMBLE_LEN - 1);
  localparam logic [CntW-1:0] MinPay  = CntW'(MIN_PAYLOAD);
  localparam logic [CntW-1:0] IfgLast = CntW'(IFG_LEN - 1);

  tx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     crc_q, crc_d;
  logic            tx_valid_q, tx_valid_d;
  logic            tx_error_q, tx_error_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            frame_done_q, frame_done_d;

  logic [CntW-1:0] cnt_inc;
  logic [7:0]      crc_byte;
  logic [31:0]     crc_next;
  logic [31:0]     fcs_word;

  assign cnt_inc  = cnt_q + CntW'(1);
  assign fcs_word = ~crc_q;
  // Pad bytes are zero on the wire and must be folded into the CRC as zero too.
  assign crc_byte = (state_q == StPad) ? 8'h00 : s_data;

  crc32_byte u_crc32_byte (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_next)
  );

  assign s_ready    = (state_q == StData) && !rst;
  assign busy       = (state_q != StIdle);
  assign tx_valid   = tx_valid_q;
  assign tx_error   = tx_error_q;
  assign tx_data    = tx_data_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    tx_valid_d   = 1'b0;
    tx_error_d   = 1'b0;
    tx_data_d    = 8'h00;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (s_valid) begin
          state_d = StPre;
        end
      end

      StPre: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ETH_PREAMBLE;
        cnt_d      = cnt_inc;
        if (cnt_q == PreLast) begin
          state_d = StSfd;
        end
      end

      StSfd: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ETH_SFD;
        cnt_d      = '0;
        crc_d      = CRC32_INIT;
        state_d    = StData;
      end

      StData: begin
        tx_valid_d = 1'b1;
        if (s_valid) begin
          tx_data_d  = s_data;
          tx_error_d = s_error;
          crc_d      = crc_next;
          cnt_d      = (cnt_q >= MinPay) ? cnt_q : cnt_inc;
          if (s_last) begin
            if (cnt_inc < MinPay) begin
              state_d = StPad;
            end else begin
              state_d = StFcs;
              cnt_d   = '0;
            end
          end
        end else begin
          // Source ran dry mid-frame: poison the byte and abandon the frame without FCS.
          tx_error_d   = 1'b1;
          frame_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = StIfg;
        end
      end

      StPad: begin
        tx_valid_d = 1'b1;
        crc_d      = crc_next;
        cnt_d      = cnt_inc;
        if (cnt_inc >= MinPay) begin
          state_d = StFcs;
          cnt_d   = '0;
        end
      end

      StFcs: begin
        tx_valid_d = 1'b1;
        tx_data_d  = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d      = cnt_inc;
        if (cnt_q[1:0] == 2'd3) begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = StIfg;
        end
      end

      StIfg: begin
        cnt_d = cnt_inc;
        if (cnt_q == IfgLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      crc_q        <= CRC32_INIT;
      tx_valid_q   <= 1'b0;
      tx_error_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      tx_valid_q   <= tx_valid_d;
      tx_error_q   <= tx_error_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_eth_mac_tx.sv
// Directed bench for eth_mac_tx: per-cycle output log, checks framing, CRC, IFG, abort and reset.
module tb_eth_mac_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_error;
  logic       tx_valid;
  logic       tx_error;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_done;

  logic [31:0] c_in, c_out;
  logic [7:0]  c_dat;

  always #5 clk = ~clk;

  eth_mac_tx dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_error    (s_error),
    .tx_valid   (tx_valid),
    .tx_error   (tx_error),
    .tx_data    (tx_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  crc32_byte u_crc_ref (
    .crc_in  (c_in),
    .data    (c_dat),
    .crc_out (c_out)
  );

  typedef struct {
    logic       v;
    logic       e;
    logic       fd;
    logic       bsy;
    logic       rdy;
    logic [7:0] d;
  } log_t;

  log_t       lg[$];
  logic [7:0] pay[$];
  bit         lst[$];
  int         idx, drop_at, err_at;
  bit         dropped, hs;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic log_t at(input int i);
    log_t r;
    r.v = 1'bx; r.e = 1'bx; r.fd = 1'bx; r.bsy = 1'bx; r.rdy = 1'bx; r.d = 8'hxx;
    if (i >= 0 && i < lg.size()) r = lg[i];
    return r;
  endfunction

  function automatic int first_valid(input int s);
    for (int i = (s < 0 ? 0 : s); i < lg.size(); i++) if (lg[i].v === 1'b1) return i;
    return -1;
  endfunction

  function automatic int run_len(input int s);
    int n = 0;
    if (s < 0) return 0;
    while (s + n < lg.size() && lg[s + n].v === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_fd();
    int n = 0;
    foreach (lg[i]) if (lg[i].fd === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_rdy();
    int n = 0;
    foreach (lg[i]) if (lg[i].rdy === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_err();
    int n = 0;
    foreach (lg[i]) if (lg[i].e !== 1'b0) n++;
    return n;
  endfunction

  function automatic logic [31:0] crc_range(input int s, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = crc_upd(c, at(s + i).d);
    return c;
  endfunction

  task automatic clear_stim();
    pay.delete(); lst.delete(); lg.delete();
    idx = 0; hs = 0; dropped = 0; drop_at = -1; err_at = -1;
  endtask

  task automatic add_frame(input int n, input logic [7:0] start, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      pay.push_back(start + 8'(i) * step);
      lst.push_back(i == n - 1);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (hs) idx++;
      lg.push_back('{v: tx_valid, e: tx_error, fd: frame_done, bsy: busy, rdy: s_ready,
                     d: tx_data});
      s_valid = (idx < pay.size());
      if (s_valid && s_ready && idx == drop_at && !dropped) begin
        s_valid = 1'b0;
        dropped = 1'b1;
      end
      s_data  = s_valid ? pay[idx] : 8'h00;
      s_last  = s_valid && lst[idx];
      s_error = s_valid && (idx == err_at);
      hs      = s_valid && s_ready;
    end
  endtask

  initial begin
    int          f, f2, n, bad;
    logic [31:0] c;
    string       s;

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_error = 1'b0;
    clear_stim();

    // CRC sub-module check value
    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      c_in = c; c_dat = s[i]; #1; c = c_out;
    end
    chk("crc_check_value", ~c, 32'hCBF43926);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_error", {31'd0, tx_error}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    // 64-byte payload 0x00..0x3F
    clear_stim();
    add_frame(64, 8'h00, 8'h01);
    run(110);
    f = first_valid(0);
    chk("f64_len", run_len(f), 76);
    bad = 0;
    for (int i = 0; i < 7; i++) if (at(f + i).d !== 8'h55) bad++;
    chk("f64_preamble", bad, 0);
    chk("f64_sfd", {24'd0, at(f + 7).d}, 32'h0000_00D5);
    bad = 0;
    for (int i = 0; i < 64; i++) if (at(f + 8 + i).d !== 8'(i)) bad++;
    chk("f64_payload", bad, 0);
    chk("f64_residue", crc_range(f + 8, 68), 32'hDEBB20E3);
    chk("f64_done_cnt", count_fd(), 1);
    chk("f64_done_pos", {31'd0, at(f + 75).fd}, 32'd1);
    chk("f64_no_err", count_err(), 0);
    chk("f64_idle_end", {31'd0, at(lg.size() - 1).bsy}, 32'd0);

    // 1-byte payload 0xAB, padded
    clear_stim();
    add_frame(1, 8'hAB, 8'h00);
    run(100);
    f = first_valid(0);
    chk("f1_len", run_len(f), 72);
    chk("f1_byte", {24'd0, at(f + 8).d}, 32'h0000_00AB);
    bad = 0;
    for (int i = 9; i < 68; i++) if (at(f + i).d !== 8'h00) bad++;
    chk("f1_pad", bad, 0);
    c = crc_upd(32'hFFFFFFFF, 8'hAB);
    for (int i = 0; i < 59; i++) c = crc_upd(c, 8'h00);
    c = ~c;
    chk("f1_fcs", {at(f + 71).d, at(f + 70).d, at(f + 69).d, at(f + 68).d}, c);
    chk("f1_ready_cycles", count_rdy(), 1);

    // Back-to-back frames with s_valid held
    clear_stim();
    add_frame(60, 8'h80, 8'h03);
    add_frame(60, 8'h11, 8'h05);
    run(200);
    f  = first_valid(0);
    chk("b2b_len1", run_len(f), 72);
    f2 = first_valid(f + 72);
    chk("b2b_gap", f2 - (f + 72), 13);
    chk("b2b_first2", {24'd0, at(f2).d}, 32'h0000_0055);
    chk("b2b_len2", run_len(f2), 72);
    chk("b2b_done_cnt", count_fd(), 2);
    chk("b2b_residue2", crc_range(f2 + 8, 64), 32'hDEBB20E3);

    // Underflow at payload byte 10; the rest goes out as a fresh frame
    clear_stim();
    add_frame(20, 8'h40, 8'h01);
    drop_at = 10;
    run(180);
    f = first_valid(0);
    chk("uf_len", run_len(f), 19);
    chk("uf_err_byte", {at(f + 18).e, at(f + 18).fd, 22'd0, at(f + 18).d}, 32'hC000_0000);
    bad = 0;
    for (int i = 0; i < 18; i++) if (at(f + i).e !== 1'b0) bad++;
    chk("uf_clean_before", bad, 0);
    chk("uf_busy_ifg", {31'd0, at(f + 18 + 11).bsy}, 32'd1);
    chk("uf_idle_after", {31'd0, at(f + 18 + 12).bsy}, 32'd0);
    f2 = first_valid(f + 19);
    chk("uf_gap", f2 - (f + 19), 13);
    chk("uf_next_len", run_len(f2), 72);
    chk("uf_next_byte0", {24'd0, at(f2 + 8).d}, 32'h0000_004A);

    // s_error on payload byte 5
    clear_stim();
    add_frame(8, 8'hC0, 8'h01);
    err_at = 5;
    run(100);
    f = first_valid(0);
    chk("err_len", run_len(f), 72);
    chk("err_flag_pos", {31'd0, at(f + 13).e}, 32'd1);
    chk("err_flag_cnt", count_err(), 1);
    chk("err_residue", crc_range(f + 8, 64), 32'hDEBB20E3);
    chk("err_done_cnt", count_fd(), 1);

    // Reset mid-payload
    clear_stim();
    add_frame(64, 8'h20, 8'h01);
    run(20);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0; hs = 0;
    @(negedge clk);
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_tx_error", {31'd0, tx_error}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    rst = 1'b0;
    clear_stim();
    add_frame(2, 8'h01, 8'h01);
    run(100);
    f = first_valid(0);
    chk("post_rst_len", run_len(f), 72);
    bad = 0;
    for (int i = 0; i < 7; i++) if (at(f + i).d !== 8'h55) bad++;
    chk("post_rst_preamble", bad, 0);
    chk("post_rst_sfd", {24'd0, at(f + 7).d}, 32'h0000_00D5);
    n = first_valid(f + 72);
    chk("post_rst_single", n, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
